// File: rtl/ifu_fetch.sv
// Instruction fetch unit. Owns the architectural PC, issues one imem read per
// instruction and hands the fetched word plus its PC to decode. Redirects
// (branch/jump/trap) replace the PC and squash any in-flight fetch.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        imem_rsp_err_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_fault_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;       // architectural PC (next instruction to deliver)
  logic [31:0] addr_q, addr_d;   // address presented on imem; lags pc while draining
  logic        drop_q, drop_d;   // outstanding/presented fetch belongs to a squashed path
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic        fault_q, fault_d;
  logic        misalign;

  assign misalign = addr_q[1:0] != 2'b00;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic: fetch sequencing, redirect squash and fault capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        addr_d  = pc_q;
      end
      REQ: begin
        if (misalign) begin
          // Nothing was presented to memory, so a redirect simply retargets.
          if (redirect_valid_i) begin
            pc_d   = redirect_pc_i;
            addr_d = redirect_pc_i;
          end else begin
            state_d = OUT;
            inst_d  = '0;
            ipc_d   = addr_q;
            fault_d = 1'b1;
          end
        end else begin
          // A presented request must stay stable until accepted; remember to
          // discard its response and refetch from the new PC afterwards.
          if (redirect_valid_i) begin
            pc_d   = redirect_pc_i;
            drop_d = 1'b1;
          end
          if (imem_req_ready_i) state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid_i) pc_d = redirect_pc_i;
        if (imem_rsp_valid_i) begin
          if (drop_q || redirect_valid_i) begin
            drop_d  = 1'b0;
            state_d = REQ;
            addr_d  = redirect_valid_i ? redirect_pc_i : pc_q;
          end else begin
            state_d = OUT;
            inst_d  = imem_rsp_err_i ? 32'h0 : imem_rsp_data_i;
            ipc_d   = addr_q;
            fault_d = imem_rsp_err_i;
          end
        end else if (redirect_valid_i) begin
          drop_d = 1'b1;
        end
      end
      OUT: begin
        // Redirect beats a same-cycle consume: held instruction is dropped.
        if (redirect_valid_i) begin
          state_d = REQ;
          pc_d    = redirect_pc_i;
          addr_d  = redirect_pc_i;
        end else if (inst_ready_i) begin
          state_d = REQ;
          pc_d    = pc_q + 32'd4;
          addr_d  = pc_q + 32'd4;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req_valid_o = (state_q == REQ) && !misalign;
  assign imem_req_addr_o  = addr_q;
  assign inst_valid_o     = (state_q == OUT);
  assign inst_o           = inst_q;
  assign inst_pc_o        = ipc_q;
  assign inst_fault_o     = fault_q;

endmodule
